// File: rtl/sram_arb_if.sv
// Interfaces for sram_arb: the single-ported SRAM access bus and one
// requester's request/response channel pair.

interface sram_rw_if_t #(
  parameter int unsigned AW = 15,
  parameter int unsigned DW = 32
);
  logic          cs;
  logic          wen;
  logic [AW-1:0] addr;
  logic [DW-1:0] wdata;
  logic [DW-1:0] rdata;

  modport mst (output cs, output wen, output addr, output wdata, input rdata);
  modport slv (input cs, input wen, input addr, input wdata, output rdata);
endinterface

interface sram_arb_port_if #(
  parameter int unsigned AW = 15,
  parameter int unsigned DW = 32
);
  logic          req_vld;
  logic          req_rdy;
  logic          req_wen;
  logic [AW-1:0] req_addr;
  logic [DW-1:0] req_wdata;
  logic          rsp_vld;
  logic          rsp_rdy;
  logic [DW-1:0] rsp_rdata;

  modport master (
    output req_vld, output req_wen, output req_addr, output req_wdata,
    output rsp_rdy,
    input  req_rdy, input rsp_vld, input rsp_rdata
  );
  modport slave (
    input  req_vld, input req_wen, input req_addr, input req_wdata,
    input  rsp_rdy,
    output req_rdy, output rsp_vld, output rsp_rdata
  );
endinterface

// File: rtl/sram_arb.sv
// sram_arb: round-robin arbiter for two requesters sharing one single-ported
// SRAM with a 1-cycle registered read. Each port owns a 2-entry response FIFO;
// a per-port credit counter admits a request only when its response is
// guaranteed a FIFO slot, so responses are never dropped under backpressure.

module sram_arb #(
  parameter int unsigned AW = 15,
  parameter int unsigned DW = 32
) (
  input  logic           clk,
  input  logic           rst,
  sram_arb_port_if.slave m0,
  sram_arb_port_if.slave m1,
  sram_rw_if_t.mst       sram_rw_mst
);

  typedef enum logic { LAST_M0 = 1'b0, LAST_M1 = 1'b1 } last_e;

  logic [1:0]    req_vld;
  logic [1:0]    req_wen;
  logic [1:0]    rsp_rdy;
  logic [AW-1:0] req_addr  [2];
  logic [DW-1:0] req_wdata [2];

  logic [1:0]    rsp_vld;
  logic [1:0]    pop;
  logic [1:0]    push;
  logic [1:0]    elig;
  logic [1:0]    gnt;
  logic          gsel;
  logic [DW-1:0] push_data;

  logic [1:0]    cred_q [2];
  logic [1:0]    cred_d [2];
  logic [1:0]    cnt_q  [2];
  logic [1:0]    cnt_d  [2];
  logic [1:0]    rp_q, rp_d;
  logic [1:0]    wp_q, wp_d;
  logic [DW-1:0] fifo_q [2][2];

  last_e         last_q, last_d;
  logic          if_vld_q, if_vld_d;
  logic          if_port_q, if_port_d;
  logic          if_wen_q, if_wen_d;

  // Flatten both requester interfaces into port-indexed vectors
  always_comb begin
    req_vld      = {m1.req_vld, m0.req_vld};
    req_wen      = {m1.req_wen, m0.req_wen};
    rsp_rdy      = {m1.rsp_rdy, m0.rsp_rdy};
    req_addr[0]  = m0.req_addr;
    req_addr[1]  = m1.req_addr;
    req_wdata[0] = m0.req_wdata;
    req_wdata[1] = m1.req_wdata;
  end

  // Response visibility, admission, round-robin grant and SRAM issue
  always_comb begin
    rsp_vld   = '0;
    pop       = '0;
    elig      = '0;
    gnt       = '0;
    last_d    = last_q;
    for (int unsigned p = 0; p < 2; p++) begin
      rsp_vld[p] = ~rst & (cnt_q[p] != 2'd0);
      pop[p]     = rsp_vld[p] & rsp_rdy[p];
      // A pop in this cycle frees a slot, so a port at zero credit may still win
      elig[p]    = ~rst & req_vld[p] & ((cred_q[p] != 2'd0) | pop[p]);
    end
    if (elig == 2'b11) begin
      gnt = (last_q == LAST_M1) ? 2'b01 : 2'b10;
    end else begin
      gnt = elig;
    end
    if (gnt[0]) begin
      last_d = LAST_M0;
    end else if (gnt[1]) begin
      last_d = LAST_M1;
    end
    gsel                = gnt[1];
    sram_rw_mst.cs      = |gnt;
    sram_rw_mst.wen     = (|gnt) ? req_wen[gsel]   : 1'b0;
    sram_rw_mst.addr    = (|gnt) ? req_addr[gsel]  : '0;
    sram_rw_mst.wdata   = (|gnt) ? req_wdata[gsel] : '0;
    if_vld_d            = |gnt;
    if_port_d           = gsel;
    if_wen_d            = (|gnt) ? req_wen[gsel] : 1'b0;
  end

  // Credit, occupancy and pointer next-state; in-flight access lands in its FIFO
  always_comb begin
    push[0]   = if_vld_q & ~if_port_q;
    push[1]   = if_vld_q &  if_port_q;
    push_data = if_wen_q ? '0 : sram_rw_mst.rdata;
    rp_d      = rp_q;
    wp_d      = wp_q;
    for (int unsigned p = 0; p < 2; p++) begin
      cred_d[p] = cred_q[p];
      cnt_d[p]  = cnt_q[p];
      case ({gnt[p], pop[p]})
        2'b10:   cred_d[p] = cred_q[p] - 2'd1;
        2'b01:   cred_d[p] = cred_q[p] + 2'd1;
        default: cred_d[p] = cred_q[p];
      endcase
      case ({push[p], pop[p]})
        2'b10:   cnt_d[p] = cnt_q[p] + 2'd1;
        2'b01:   cnt_d[p] = cnt_q[p] - 2'd1;
        default: cnt_d[p] = cnt_q[p];
      endcase
      if (push[p]) wp_d[p] = ~wp_q[p];
      if (pop[p])  rp_d[p] = ~rp_q[p];
    end
  end

  // Drive response channels; everything reads as zero while reset is held
  always_comb begin
    m0.req_rdy   = gnt[0];
    m1.req_rdy   = gnt[1];
    m0.rsp_vld   = rsp_vld[0];
    m1.rsp_vld   = rsp_vld[1];
    m0.rsp_rdata = rst ? '0 : fifo_q[0][rp_q[0]];
    m1.rsp_rdata = rst ? '0 : fifo_q[1][rp_q[1]];
  end

  // Control state: credits, FIFO occupancy/pointers, in-flight stage, last grant
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int unsigned p = 0; p < 2; p++) begin
        cred_q[p] <= 2'd2;
        cnt_q[p]  <= 2'd0;
      end
      rp_q      <= '0;
      wp_q      <= '0;
      if_vld_q  <= 1'b0;
      if_port_q <= 1'b0;
      if_wen_q  <= 1'b0;
      last_q    <= LAST_M1;
    end else begin
      for (int unsigned p = 0; p < 2; p++) begin
        cred_q[p] <= cred_d[p];
        cnt_q[p]  <= cnt_d[p];
      end
      rp_q      <= rp_d;
      wp_q      <= wp_d;
      if_vld_q  <= if_vld_d;
      if_port_q <= if_port_d;
      if_wen_q  <= if_wen_d;
      last_q    <= last_d;
    end
  end

  // FIFO storage; stale entries are invisible because occupancy gates rsp_vld
  always_ff @(posedge clk) begin
    for (int unsigned p = 0; p < 2; p++) begin
      if (push[p]) fifo_q[p][wp_q[p]] <= push_data;
    end
  end

  a_cred0_max: assert property (@(posedge clk) disable iff (rst) cred_q[0] <= 2'd2);
  a_cred1_max: assert property (@(posedge clk) disable iff (rst) cred_q[1] <= 2'd2);
  a_cred0_min: assert property (@(posedge clk) disable iff (rst)
                                !(gnt[0] && !pop[0] && cred_q[0] == 2'd0));
  a_cred1_min: assert property (@(posedge clk) disable iff (rst)
                                !(gnt[1] && !pop[1] && cred_q[1] == 2'd0));
  a_fifo0_ovf: assert property (@(posedge clk) disable iff (rst)
                                !(push[0] && cnt_q[0] == 2'd2));
  a_fifo1_ovf: assert property (@(posedge clk) disable iff (rst)
                                !(push[1] && cnt_q[1] == 2'd2));

endmodule
